// File: rtl/sort_pkg.sv
// Shared types and width helpers for the streaming top-K tracker.
package sort_pkg;
  localparam int MAX_K = 64;

  typedef enum logic {ACCUM = 1'b0, DUMP = 1'b1} state_e;

  function automatic int cnt_w(input int k);
    return $clog2(k + 1);
  endfunction

  function automatic int sum_w(input int w, input int k);
    return w + $clog2(k);
  endfunction
endpackage

// File: rtl/sort_topk_cell.sv
// One slot of the descending sorted array. It holds an entry and its valid bit.
// It either keeps its value, loads the new sample, or takes its upper neighbour's value.
module sort_topk_cell #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_x,
  input  logic         ins_i,
  input  logic         clr_i,
  input  logic [W-1:0] din_i,
  input  logic         up_ge_i,
  input  logic [W-1:0] up_s_i,
  input  logic         up_v_i,
  output logic         ge_o,
  output logic [W-1:0] s_o,
  output logic         v_o,
  output logic [W-1:0] s_nxt_o
);
  logic [W-1:0] s_q, s_d;
  logic         v_q, v_d;

  // Ties count as >=, so a new sample lands after its equals.
  assign ge_o = v_q && (s_q >= din_i);

  always_comb begin
    s_d = s_q;
    v_d = v_q;
    if (clr_i) begin
      s_d = '0;
      v_d = 1'b0;
    end else if (ins_i && !ge_o) begin
      if (up_ge_i) begin
        s_d = din_i;
        v_d = 1'b1;
      end else begin
        s_d = up_s_i;
        v_d = up_v_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_x) begin
      s_q <= '0;
      v_q <= 1'b0;
    end else begin
      s_q <= s_d;
      v_q <= v_d;
    end
  end

  assign s_o     = s_q;
  assign v_o     = v_q;
  assign s_nxt_o = s_d;
endmodule

// File: rtl/sort_topk.sv
// Streaming top-K tracker. It keeps the K largest samples of a frame, sorted in descending order.
// On frame end it drains them, largest first, over a valid/ready port.
module sort_topk
  import sort_pkg::*;
#(
  parameter  int W  = 12,
  parameter  int K  = 16,
  localparam int CW = cnt_w(K),
  localparam int SW = sum_w(W, K)
) (
  input  logic          clk,
  input  logic          rst_x,
  input  logic          DataEn,
  input  logic [W-1:0]  DataIn,
  input  logic          FrameEnd,
  output logic [W-1:0]  DataMax,
  output logic [W-1:0]  DataMin,
  output logic [SW-1:0] DataSumOut,
  output logic [CW-1:0] Count,
  output logic          Busy,
  output logic          DropPulse,
  output logic          OutValid,
  output logic [W-1:0]  OutData,
  output logic          OutLast,
  input  logic          OutReady
);
  logic [K-1:0]        ge, v;
  logic [K-1:0][W-1:0] s, s_nxt;
  logic                ins, clr;
  logic [W-1:0]        evict;

  state_e        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d, cnt_q, cnt_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [W-1:0]  min_q, min_d, od_q, od_d;
  logic          ov_q, ov_d, ol_q, ol_d, drop_q, drop_d, busy_q, busy_d;

  for (genvar i = 0; i < K; i++) begin : g_cell
    if (i == 0) begin : g_head
      sort_topk_cell #(.W(W)) u_cell (
        .clk(clk), .rst_x(rst_x), .ins_i(ins), .clr_i(clr), .din_i(DataIn),
        .up_ge_i(1'b1), .up_s_i('0), .up_v_i(1'b0),
        .ge_o(ge[i]), .s_o(s[i]), .v_o(v[i]), .s_nxt_o(s_nxt[i])
      );
    end else begin : g_body
      sort_topk_cell #(.W(W)) u_cell (
        .clk(clk), .rst_x(rst_x), .ins_i(ins), .clr_i(clr), .din_i(DataIn),
        .up_ge_i(ge[i-1]), .up_s_i(s[i-1]), .up_v_i(v[i-1]),
        .ge_o(ge[i]), .s_o(s[i]), .v_o(v[i]), .s_nxt_o(s_nxt[i])
      );
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    min_d   = min_q;
    ov_d    = ov_q;
    od_d    = od_q;
    ol_d    = ol_q;
    drop_d  = 1'b0;
    ins     = 1'b0;
    clr     = 1'b0;
    evict   = '0;
    unique case (state_q)
      ACCUM: begin
        ins = DataEn;
        // The sample lands in the array unless the array is full and the sample is <= the tail.
        if (DataEn && !ge[K-1]) begin
          if (v[K-1]) evict = s[K-1];
          else        cnt_d = cnt_q + 1'b1;
          sum_d = sum_q + SW'(DataIn) - SW'(evict);
          for (int i = 0; i < K; i++)
            if (CW'(i) + 1'b1 == cnt_d) min_d = s_nxt[i];
        end
        if (FrameEnd && cnt_d != '0) begin
          state_d = DUMP;
          idx_d   = '0;
          ov_d    = 1'b1;
          od_d    = s_nxt[0];
          ol_d    = (cnt_d == CW'(1));
        end
      end
      DUMP: begin
        drop_d = DataEn;
        if (ov_q && OutReady) begin
          if (ol_q) begin
            clr     = 1'b1;
            state_d = ACCUM;
            idx_d   = '0;
            cnt_d   = '0;
            sum_d   = '0;
            min_d   = '0;
            ov_d    = 1'b0;
            od_d    = '0;
            ol_d    = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
            for (int i = 0; i < K; i++)
              if (CW'(i) == idx_d) od_d = s[i];
            ol_d = (idx_d + 1'b1 == cnt_q);
          end
        end
      end
      default: state_d = ACCUM;
    endcase
    busy_d = (state_d == DUMP);
  end

  always_ff @(posedge clk) begin
    if (!rst_x) begin
      state_q <= ACCUM;
      idx_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      min_q   <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ol_q    <= 1'b0;
      drop_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      min_q   <= min_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ol_q    <= ol_d;
      drop_q  <= drop_d;
      busy_q  <= busy_d;
    end
  end

  assign DataMax    = s[0];
  assign DataMin    = min_q;
  assign DataSumOut = sum_q;
  assign Count      = cnt_q;
  assign Busy       = busy_q;
  assign DropPulse  = drop_q;
  assign OutValid   = ov_q;
  assign OutData    = od_q;
  assign OutLast    = ol_q;
endmodule

// File: tb/tb_sort_topk.sv
// Directed bench for sort_topk. Instance a uses K=4 and instance b uses K=16; both share one stimulus stream.
module tb_sort_topk;
  logic        clk, rst_x, DataEn, FrameEnd, OutReady;
  logic [11:0] DataIn;

  logic [11:0] a_max, a_min, a_od, b_max, b_min, b_od;
  logic [13:0] a_sum;
  logic [15:0] b_sum;
  logic [2:0]  a_cnt;
  logic [4:0]  b_cnt;
  logic        a_busy, a_drop, a_ov, a_ol, b_busy, b_drop, b_ov, b_ol;

  int checks = 0;
  int failures = 0;

  sort_topk #(.W(12), .K(4)) u_a (
    .clk(clk), .rst_x(rst_x), .DataEn(DataEn), .DataIn(DataIn), .FrameEnd(FrameEnd),
    .DataMax(a_max), .DataMin(a_min), .DataSumOut(a_sum), .Count(a_cnt),
    .Busy(a_busy), .DropPulse(a_drop), .OutValid(a_ov), .OutData(a_od),
    .OutLast(a_ol), .OutReady(OutReady)
  );

  sort_topk #(.W(12), .K(16)) u_b (
    .clk(clk), .rst_x(rst_x), .DataEn(DataEn), .DataIn(DataIn), .FrameEnd(FrameEnd),
    .DataMax(b_max), .DataMin(b_min), .DataSumOut(b_sum), .Count(b_cnt),
    .Busy(b_busy), .DropPulse(b_drop), .OutValid(b_ov), .OutData(b_od),
    .OutLast(b_ol), .OutReady(OutReady)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [11:0] d);
    DataEn = 1'b1;
    DataIn = d;
    tick();
    DataEn = 1'b0;
  endtask

  task automatic stat(input string tag, input int mx, input int mn, input int sm, input int cn);
    chk({tag, "_max"}, 32'(a_max), mx);
    chk({tag, "_min"}, 32'(a_min), mn);
    chk({tag, "_sum"}, 32'(a_sum), sm);
    chk({tag, "_cnt"}, 32'(a_cnt), cn);
  endtask

  int ins_v[5]  = '{5, 1, 9, 3, 7};
  int ins_mx[5] = '{5, 5, 9, 9, 9};
  int ins_mn[5] = '{5, 1, 1, 1, 3};
  int ins_sm[5] = '{5, 6, 15, 18, 24};
  int ins_cn[5] = '{1, 2, 3, 4, 4};
  int dr1[4]    = '{9, 7, 5, 4};
  int dr2[4]    = '{9, 7, 6, 5};
  int pre[4]    = '{9, 7, 5, 4};

  initial begin
    clk = 1'b0; rst_x = 1'b0; DataEn = 1'b0; DataIn = '0; FrameEnd = 1'b0; OutReady = 1'b0;
    tick(); tick();
    stat("rst", 0, 0, 0, 0);
    chk("rst_ov", 32'(a_ov), 0);
    chk("rst_busy", 32'(a_busy), 0);
    rst_x = 1'b1;

    for (int i = 0; i < 5; i++) begin
      feed(ins_v[i]);
      stat("ins", ins_mx[i], ins_mn[i], ins_sm[i], ins_cn[i]);
    end
    feed(3);
    stat("tie", 9, 3, 24, 4);
    feed(4);
    stat("ins4", 9, 4, 25, 4);

    FrameEnd = 1'b1;
    tick();
    FrameEnd = 1'b0;
    chk("fe_busy", 32'(a_busy), 1);
    for (int b = 0; b < 4; b++) begin
      chk("dr_ov", 32'(a_ov), 1);
      chk("dr_data", 32'(a_od), dr1[b]);
      chk("dr_last", 32'(a_ol), 32'(b == 3));
      OutReady = 1'b0;
      tick();
      chk("stall_data", 32'(a_od), dr1[b]);
      chk("stall_last", 32'(a_ol), 32'(b == 3));
      chk("hold_max", 32'(a_max), 9);
      chk("hold_sum", 32'(a_sum), 25);
      OutReady = 1'b1;
      tick();
    end
    OutReady = 1'b0;
    chk("post_ov", 32'(a_ov), 0);
    chk("post_busy", 32'(a_busy), 0);
    stat("post", 0, 0, 0, 0);

    for (int i = 0; i < 4; i++) feed(pre[i]);
    DataEn = 1'b1; DataIn = 6; FrameEnd = 1'b1;
    tick();
    DataEn = 1'b0; FrameEnd = 1'b0;
    stat("coll", 9, 5, 27, 4);
    OutReady = 1'b1;
    for (int b = 0; b < 4; b++) begin
      chk("coll_ov", 32'(a_ov), 1);
      chk("coll_data", 32'(a_od), dr2[b]);
      chk("coll_last", 32'(a_ol), 32'(b == 3));
      if (b == 0) begin
        DataEn = 1'b1;
        DataIn = 8;
      end
      tick();
      DataEn = 1'b0;
      chk("drop", 32'(a_drop), 32'(b == 0));
    end
    OutReady = 1'b0;
    chk("coll_cnt", 32'(a_cnt), 0);

    feed(1);
    stat("nf", 1, 1, 1, 1);
    FrameEnd = 1'b1;
    tick();
    FrameEnd = 1'b0;
    chk("nf_data", 32'(a_od), 1);
    chk("nf_last", 32'(a_ol), 1);
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    chk("nf_done", 32'(a_ov), 0);

    FrameEnd = 1'b1;
    tick();
    FrameEnd = 1'b0;
    chk("empty_ov", 32'(a_ov), 0);
    chk("empty_busy", 32'(a_busy), 0);
    tick();
    chk("empty_ov2", 32'(a_ov), 0);

    feed(2);
    feed(3);
    rst_x = 1'b0;
    tick();
    stat("mrst", 0, 0, 0, 0);
    chk("mrst_b_cnt", 32'(b_cnt), 0);
    tick(); tick();
    rst_x = 1'b1;
    feed(7);
    stat("rrel", 7, 7, 7, 1);

    rst_x = 1'b0;
    tick();
    rst_x = 1'b1;
    for (int i = 0; i < 20; i++) feed(12'hfff);
    chk("wide_cnt", 32'(b_cnt), 16);
    chk("wide_sum", 32'(b_sum), 65520);
    chk("wide_max", 32'(b_max), 4095);
    chk("wide_min", 32'(b_min), 4095);
    chk("k4_sum", 32'(a_sum), 16380);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sort_topk.md
# sort_topk

Streaming top-K tracker: accepts one W-bit sample per cycle and keeps the K largest values of the current frame in a descending sorted register array. It reports the running maximum, the K-th largest value, the exact sum of the kept set, and the kept count. On frame end it drains the kept values, largest first, over a valid/ready port, then clears for the next frame. It is the parametrised successor of the fixed 16-entry, 12-bit `sort2in1` max/sum block and sits between the sample source and the statistics/readout logic.

## Interface
- `W`, 12: sample width.
- `K`, 16: kept entries, 2..64.
- `CW`, derived `$clog2(K+1)`: count width.
- `SW`, derived `W+$clog2(K)`: sum width. Overflow is impossible.
- `clk` in 1: single clock, rising edge.
- `rst_x` in 1: reset, synchronous, active-low.
- `DataEn` in 1: `DataIn` valid this cycle.
- `DataIn` in W: unsigned sample.
- `FrameEnd` in 1: one-cycle pulse that closes the frame.
- `DataMax` out W: largest kept value (entry 0), 0 when empty.
- `DataMin` out W: smallest kept value (entry Count-1), 0 when empty.
- `DataSumOut` out SW: sum of kept values.
- `Count` out CW: number of valid entries, 0..K.
- `Busy` out 1: high while in DUMP.
- `DropPulse` out 1: one-cycle pulse when a `DataEn` sample is discarded because the block is in DUMP.
- `OutValid` out 1: readout valid.
- `OutData` out W: readout value.
- `OutLast` out 1: marks the final readout beat.
- `OutReady` in 1: readout accept.

## Operation
- The array holds `S[0..K-1]` with a valid bit per entry. It is always packed and descending; `S[0]` is the largest.
- State machine: ACCUM, DUMP.
- **ACCUM, `DataEn`=1:**
  - Insert position p = the number of valid entries with `S[i] >= DataIn`. A tie places the new sample after its equals.
  - If p < K: entries p..K-2 shift down by one and `S[p]` = `DataIn`.
  - If `Count`==K, old `S[K-1]` is evicted; otherwise `Count` increments.
  - `DataSumOut` += `DataIn` − (evicted value, or 0).
  - If p == K (array full and `DataIn` <= `S[K-1]`): nothing changes.
- **ACCUM, `FrameEnd`=1:**
  - A same-cycle `DataEn` sample is applied first.
  - If the resulting `Count` > 0, go to DUMP with index=0.
  - If `Count`==0, stay in ACCUM and emit nothing.
- **DUMP:**
  - `OutValid`=1, `OutData`=`S[index]`, `OutLast`=(index==`Count`-1).
  - A beat transfers when `OutValid`&&`OutReady`, and index then increments.
  - `OutData` and `OutLast` stay stable while `OutValid`=1 and `OutReady`=0.
  - After the last transfer: clear every valid bit and set `Count`, `DataSumOut` and all S to 0, then return to ACCUM.
  - `DataEn` in DUMP drops the sample and pulses `DropPulse`.
  - `FrameEnd` in DUMP is ignored.
  - `DataMax`, `DataMin` and `DataSumOut` hold the frame values throughout DUMP.
- Reset (`rst_x`=0 at a clock edge), including mid-ACCUM or mid-DUMP:
  - Go to ACCUM and clear the array.
  - All outputs become 0 from the following cycle; an in-flight readout is abandoned.

## Timing
- All outputs are registered.
- A sample presented at edge n is reflected in `DataMax`, `DataMin`, `DataSumOut` and `Count` after edge n. Latency is 1 cycle.
- Throughput: one sample per cycle sustained in ACCUM.
- `FrameEnd` at edge n gives `OutValid`=1 after edge n.
- With `OutReady` held high, one beat transfers per cycle. The last beat (`OutLast`) completes at edge n+Count.
- The clear and return to ACCUM take effect after that edge. A sample at edge n+Count+1 is accepted into the new frame.
- `OutValid` never depends combinationally on `OutReady`.
- Reset values: all outputs 0, state ACCUM.

## Structure
- Package `sort_pkg` holds:
  - the state enum (ACCUM, DUMP);
  - functions `cnt_w(K)` and `sum_w(W,K)`;
  - the max-K constant, 64.
- Sub-module `sort_topk_cell`, instantiated K times. Each cell holds one entry and its valid bit, and compares against `DataIn` producing a ge-flag; shift/load/clear muxes are selected from its own and the upper neighbour's ge-flags.
- The top level contains the FSM, count, sum, eviction select and readout index mux.

## Test plan
- Reset: after streaming, hold `rst_x`=0 for 3 cycles, then release. Required: all outputs 0 from the first reset edge; the first new sample 7 gives Max=7, Sum=7, Count=1.
- Insertion (K=4): feed 5,1,9,3,7 on consecutive cycles. Required: array 9,7,5,3; Max=9, Min=3, Sum=24, Count=4; 1 is evicted.
- Ties and discard: from 9,7,5,3, feed 3. Required: no change, Sum=24. Then feed 4. Required: 9,7,5,4, Min=4, Sum=25.
- Drain with backpressure: pulse `FrameEnd` and toggle `OutReady` 1,0,1,0. Required: beats 9,7,5,4 in order, each held while stalled, `OutLast` only on 4; then Count=0 and Sum=0 on the cycle after the last transfer.
- Collisions:
  - `DataEn`=1 with 6 in the same cycle as `FrameEnd` from 9,7,5,4. Required: dump is 9,7,6,5.
  - `DataEn` during DUMP. Required: `DropPulse`=1 and the value is absent from the next frame.
  - `FrameEnd` when empty. Required: no `OutValid`.
- Width corner (W=12, K=16): feed 4095 twenty times. Required: Count=16, DataSumOut=65520 (16 bits, no wrap), Max=Min=4095.
